// File: rtl/ysyx_24100006_fencei_ctrl.sv
// ysyx_24100006_fencei_ctrl: fence.i sequencer that drains the LSU, walks every icache line with invalidates, then releases EXE
module ysyx_24100006_fencei_ctrl #(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             is_fence_i,
  input  logic             exe_out_valid,
  input  logic             exe_in_ready,
  input  logic             kill,
  input  logic             mem_idle,
  output logic             inv_valid,
  output logic [IDX_W-1:0] inv_idx,
  input  logic             inv_ready,
  output logic             icache_flush_done,
  output logic             flush_busy,
  output logic [CNT_W-1:0] fence_cnt
);
  typedef enum logic [1:0] {IDLE, DRAIN, INV, DONE} state_e;
  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             fence_req, fire, last;
  assign fence_req = is_fence_i & exe_out_valid & ~kill;
  assign fire      = exe_out_valid & exe_in_ready;
  assign last      = idx_q == IDX_W'(NUM_LINES - 1);
  assign inv_idx   = idx_q;
  // sequencer: outputs are registered alongside the state so they change only on transitions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      idx_q             <= '0;
      inv_valid         <= 1'b0;
      icache_flush_done <= 1'b0;
      flush_busy        <= 1'b0;
      fence_cnt         <= '0;
    end else begin
      case (state_q)
        IDLE: if (fence_req) begin
          state_q    <= DRAIN;
          flush_busy <= 1'b1;
        end
        DRAIN: if (kill) begin
          state_q    <= IDLE;
          flush_busy <= 1'b0;
        end else if (mem_idle) begin
          state_q   <= INV;
          inv_valid <= 1'b1;
          idx_q     <= '0;
        end
        INV: if (kill) begin
          state_q    <= IDLE;
          inv_valid  <= 1'b0;
          flush_busy <= 1'b0;
          idx_q      <= '0;
        end else if (inv_ready) begin
          if (last) begin
            state_q           <= DONE;
            inv_valid         <= 1'b0;
            icache_flush_done <= 1'b1;
            idx_q             <= '0;
            fence_cnt         <= fence_cnt + CNT_W'(1);
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: if (fire | kill) begin
          state_q           <= IDLE;
          icache_flush_done <= 1'b0;
          flush_busy        <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_24100006_fencei_ctrl.sv
// tb_ysyx_24100006_fencei_ctrl: scoreboarded bench for the fence.i sequencer
module tb_ysyx_24100006_fencei_ctrl;
  logic        clk = 0, reset = 1, is_fence_i = 0, exe_out_valid = 0, exe_in_ready = 1;
  logic        kill = 0, mem_idle = 1, inv_ready = 1;
  logic        inv_valid, icache_flush_done, flush_busy;
  logic [3:0]  inv_idx;
  logic [31:0] fence_cnt;
  logic [31:0] exp_cnt = 0;
  int          checks = 0, errors = 0;
  int          exp_q[$];
  int          sb_e;
  always #5 clk = ~clk;
  ysyx_24100006_fencei_ctrl dut (
    .clk(clk), .reset(reset), .is_fence_i(is_fence_i), .exe_out_valid(exe_out_valid),
    .exe_in_ready(exe_in_ready), .kill(kill), .mem_idle(mem_idle), .inv_valid(inv_valid),
    .inv_idx(inv_idx), .inv_ready(inv_ready), .icache_flush_done(icache_flush_done),
    .flush_busy(flush_busy), .fence_cnt(fence_cnt)
  );
  // every accepted invalidate must match the next expected line index
  always @(negedge clk) begin
    if (!reset && inv_valid && inv_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra inv_idx got %0d expected no invalidate", inv_idx);
      end else begin
        sb_e = exp_q.pop_front();
        if (inv_idx !== 4'(sb_e)) begin
          errors++;
          $display("FAIL sb_idx inv_idx got %0d expected %0d", inv_idx, sb_e);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_all();
    for (int i = 0; i < 16; i++) exp_q.push_back(i);
  endtask
  task automatic test_reset();
    reset = 1;
    tick();
    tick();
    checks++;
    if ({inv_valid, inv_idx, icache_flush_done, flush_busy, fence_cnt} !== '0) begin
      errors++;
      $display("FAIL reset got v%b i%0d d%b b%b c%0d expected all 0", inv_valid, inv_idx, icache_flush_done, flush_busy, fence_cnt);
    end
    reset = 0;
    tick();
    tick();
    checks++;
    if ({inv_valid, icache_flush_done, flush_busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle got %b expected 000", {inv_valid, icache_flush_done, flush_busy});
    end
  endtask
  task automatic test_basic();
    logic [2:0] e;
    is_fence_i = 1; exe_out_valid = 1; mem_idle = 1; inv_ready = 1; exe_in_ready = 1;
    push_all();
    for (int c = 0; c <= 19; c++) begin
      if (c == 19) begin is_fence_i = 0; exe_out_valid = 0; end
      if (c == 18) exp_cnt++;
      @(negedge clk);
      e = {c >= 2 && c <= 17, c == 18, c >= 1 && c <= 18};
      checks++;
      if ({inv_valid, icache_flush_done, flush_busy} !== e) begin
        errors++;
        $display("FAIL basic c%0d {inv_valid,done,busy} got %b expected %b", c, {inv_valid, icache_flush_done, flush_busy}, e);
      end
      checks++;
      if (fence_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL basic_cnt c%0d got %0d expected %0d", c, fence_cnt, exp_cnt);
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_left got %0d pending expected 0", exp_q.size());
    end
  endtask
  task automatic test_drain();
    logic [2:0] e;
    is_fence_i = 1; exe_out_valid = 1; inv_ready = 1; exe_in_ready = 1;
    push_all();
    for (int c = 0; c <= 24; c++) begin
      mem_idle = c >= 6;
      if (c == 24) begin is_fence_i = 0; exe_out_valid = 0; end
      if (c == 23) exp_cnt++;
      @(negedge clk);
      e = {c >= 7 && c <= 22, c == 23, c >= 1 && c <= 23};
      checks++;
      if ({inv_valid, icache_flush_done, flush_busy} !== e) begin
        errors++;
        $display("FAIL drain c%0d {inv_valid,done,busy} got %b expected %b", c, {inv_valid, icache_flush_done, flush_busy}, e);
      end
      tick();
    end
    checks++;
    if (fence_cnt !== exp_cnt || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_end cnt got %0d expected %0d, pending %0d", fence_cnt, exp_cnt, exp_q.size());
    end
  endtask
  task automatic test_backpressure();
    logic [2:0] e;
    is_fence_i = 1; exe_out_valid = 1; mem_idle = 1; exe_in_ready = 1;
    push_all();
    for (int c = 0; c <= 35; c++) begin
      inv_ready = (c % 2) == 1;
      if (c == 35) begin is_fence_i = 0; exe_out_valid = 0; end
      if (c == 34) exp_cnt++;
      @(negedge clk);
      e = {c >= 2 && c <= 33, c == 34, c >= 1 && c <= 34};
      checks++;
      if ({inv_valid, icache_flush_done, flush_busy} !== e) begin
        errors++;
        $display("FAIL bp c%0d {inv_valid,done,busy} got %b expected %b", c, {inv_valid, icache_flush_done, flush_busy}, e);
      end
      if (c >= 2 && c <= 33) begin
        checks++;
        if (inv_idx !== 4'((c - 2) / 2)) begin
          errors++;
          $display("FAIL bp_idx c%0d got %0d expected %0d", c, inv_idx, (c - 2) / 2);
        end
      end
      tick();
    end
    inv_ready = 1;
    checks++;
    if (fence_cnt !== exp_cnt || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_end cnt got %0d expected %0d, pending %0d", fence_cnt, exp_cnt, exp_q.size());
    end
  endtask
  task automatic test_kill();
    logic [2:0] e;
    exe_out_valid = 1; mem_idle = 1; inv_ready = 1; exe_in_ready = 1;
    for (int c = 0; c <= 13; c++) begin
      is_fence_i = (c <= 7) || (c >= 9 && c <= 11);
      kill = c == 7 || c == 11;
      if (c == 0 || c == 9) push_all();
      if (c == 8 || c == 12) exp_q.delete();
      @(negedge clk);
      e = {(c >= 2 && c <= 7) || c == 11, 1'b0, (c >= 1 && c <= 7) || c == 10 || c == 11};
      checks++;
      if ({inv_valid, icache_flush_done, flush_busy} !== e) begin
        errors++;
        $display("FAIL kill c%0d {inv_valid,done,busy} got %b expected %b", c, {inv_valid, icache_flush_done, flush_busy}, e);
      end
      if (c == 7 || c == 8 || c == 11 || c == 12) begin
        checks++;
        if (inv_idx !== (c == 7 ? 4'd5 : 4'd0) || fence_cnt !== exp_cnt) begin
          errors++;
          $display("FAIL kill_idx c%0d idx got %0d cnt got %0d expected idx %0d cnt %0d", c, inv_idx, fence_cnt, c == 7 ? 5 : 0, exp_cnt);
        end
      end
      tick();
    end
    kill = 0; is_fence_i = 0; exe_out_valid = 0;
  endtask
  task automatic test_stall();
    logic [2:0] e;
    is_fence_i = 1; exe_out_valid = 1; mem_idle = 1; inv_ready = 1;
    push_all();
    for (int c = 0; c <= 23; c++) begin
      exe_in_ready = !(c >= 18 && c <= 21);
      if (c == 23) begin is_fence_i = 0; exe_out_valid = 0; end
      if (c == 18) exp_cnt++;
      @(negedge clk);
      e = {c >= 2 && c <= 17, c >= 18 && c <= 22, c >= 1 && c <= 22};
      checks++;
      if ({inv_valid, icache_flush_done, flush_busy} !== e) begin
        errors++;
        $display("FAIL stall c%0d {inv_valid,done,busy} got %b expected %b", c, {inv_valid, icache_flush_done, flush_busy}, e);
      end
      checks++;
      if (fence_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL stall_cnt c%0d got %0d expected %0d", c, fence_cnt, exp_cnt);
      end
      tick();
    end
    exe_in_ready = 1;
  endtask
  task automatic test_back_to_back();
    logic [2:0] e;
    is_fence_i = 1; exe_out_valid = 1; mem_idle = 1; inv_ready = 1; exe_in_ready = 1;
    push_all();
    for (int c = 0; c <= 21; c++) begin
      kill = c == 20;
      if (c == 21) begin is_fence_i = 0; exe_out_valid = 0; end
      if (c == 18) exp_cnt++;
      @(negedge clk);
      e = {c >= 2 && c <= 17, c == 18, (c >= 1 && c <= 18) || c == 20};
      checks++;
      if ({inv_valid, icache_flush_done, flush_busy} !== e) begin
        errors++;
        $display("FAIL b2b c%0d {inv_valid,done,busy} got %b expected %b", c, {inv_valid, icache_flush_done, flush_busy}, e);
      end
      tick();
    end
    kill = 0;
    checks++;
    if (fence_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL b2b_cnt got %0d expected %0d", fence_cnt, exp_cnt);
    end
  endtask
  task automatic test_reset_mid();
    is_fence_i = 1; exe_out_valid = 1; mem_idle = 1; inv_ready = 1; exe_in_ready = 1;
    push_all();
    for (int c = 0; c < 11; c++) tick();
    #1;
    checks++;
    if (inv_idx !== 4'd9 || inv_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre got idx %0d valid %b expected idx 9 valid 1", inv_idx, inv_valid);
    end
    reset = 1;
    #1;
    exp_cnt = 0;
    exp_q.delete();
    checks++;
    if ({inv_valid, inv_idx, icache_flush_done, flush_busy, fence_cnt} !== '0) begin
      errors++;
      $display("FAIL rst_async got v%b i%0d d%b b%b c%0d expected all 0", inv_valid, inv_idx, icache_flush_done, flush_busy, fence_cnt);
    end
    tick();
    reset = 0; is_fence_i = 0;
    for (int c = 0; c < 20; c++) begin
      mem_idle = 1'($urandom); inv_ready = 1'($urandom); exe_in_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({inv_valid, icache_flush_done, flush_busy} !== 3'b000 || fence_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL rst_idle c%0d got %b cnt %0d expected 000 cnt %0d", c, {inv_valid, icache_flush_done, flush_busy}, fence_cnt, exp_cnt);
      end
      tick();
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_drain();
    test_backpressure();
    test_kill();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
